// File: rtl/lpif_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lpif_pkg - LPIF state encodings, beat layout and framing width helper. Rev 1.0
// ----------------------------------------------------------------------------
package lpif_pkg;

  typedef enum logic [3:0] {
    LPIF_RESET     = 4'b0000,
    LPIF_ACTIVE    = 4'b0001,
    LPIF_IDLE_L1_1 = 4'b0100,
    LPIF_RETRAIN   = 4'b1011,
    LPIF_LINKRESET = 4'b1001,
    LPIF_DISABLED  = 4'b1100
  } lpif_state_e;

  // NOP shares the RESET code, so it cannot live in the enum.
  localparam logic [3:0] LPIF_NOP = 4'b0000;

  localparam int LPIF_BEAT_BW = 32;

  function automatic int lpif_fr_width(input int bus_width);
    return bus_width / 8;
  endfunction

  typedef struct packed {
    logic [LPIF_BEAT_BW-1:0]   data;
    logic [LPIF_BEAT_BW/8-1:0] valid;
    logic [LPIF_BEAT_BW/8-1:0] tlp_start;
    logic [LPIF_BEAT_BW/8-1:0] tlp_end;
    logic [LPIF_BEAT_BW/8-1:0] dllp_start;
    logic [LPIF_BEAT_BW/8-1:0] dllp_end;
    logic [LPIF_BEAT_BW/8-1:0] tlpedb;
  } lpif_beat_t;

endpackage
`default_nettype wire

// File: rtl/lpif_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lpif_tx_fifo - synchronous FIFO with full/empty and a one-cycle flush. Rev 1.0
// ----------------------------------------------------------------------------
module lpif_tx_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lpif_pl_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lpif_pl_responder - LPIF PHY-side state FSM, exit-CG handshake and TX buffer.
// Optional framing checker under LPIF_FRAMING_CHECK_EN.                 Rev 1.0
// ----------------------------------------------------------------------------
module lpif_pl_responder
  import lpif_pkg::*;
#(
  parameter int BUS_WIDTH       = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int EXIT_CG_TIMEOUT = 255
) (
  input  logic                                  lclk,
  input  logic                                  reset_n,
  input  logic [3:0]                            lp_state_req,
  output logic [3:0]                            pl_state_sts,
  input  logic                                  lp_irdy,
  input  logic [BUS_WIDTH-1:0]                  lp_data,
  input  logic [lpif_fr_width(BUS_WIDTH)-1:0]   lp_valid,
  input  logic [lpif_fr_width(BUS_WIDTH)-1:0]   lp_tlp_start,
  input  logic [lpif_fr_width(BUS_WIDTH)-1:0]   lp_tlp_end,
  input  logic [lpif_fr_width(BUS_WIDTH)-1:0]   lp_dllp_start,
  input  logic [lpif_fr_width(BUS_WIDTH)-1:0]   lp_dllp_end,
  input  logic [lpif_fr_width(BUS_WIDTH)-1:0]   lp_tlpedb,
  output logic                                  pl_trdy,
  output logic                                  pl_exit_cg_req,
  input  logic                                  lp_exit_cg_ack,
  input  logic                                  phy_link_up,
  input  logic                                  phy_retrain,
  output logic [BUS_WIDTH+6*(BUS_WIDTH/8)-1:0]  tx_data,
  output logic                                  tx_valid,
  input  logic                                  tx_ready,
  output logic                                  cg_timeout
`ifdef LPIF_FRAMING_CHECK_EN
  ,output logic                                 framing_err
`endif
);

  localparam int FW    = lpif_fr_width(BUS_WIDTH);
  localparam int BEAT_W = BUS_WIDTH + 6 * FW;
  localparam int CNT_W = (EXIT_CG_TIMEOUT < 2) ? 1 : $clog2(EXIT_CG_TIMEOUT + 1);

  localparam logic [3:0] ST_RESET     = LPIF_RESET;
  localparam logic [3:0] ST_ACTIVE    = LPIF_ACTIVE;
  localparam logic [3:0] ST_IDLE_L1_1 = LPIF_IDLE_L1_1;
  localparam logic [3:0] ST_RETRAIN   = LPIF_RETRAIN;
  localparam logic [3:0] ST_LINKRESET = LPIF_LINKRESET;
  localparam logic [3:0] ST_DISABLED  = LPIF_DISABLED;

  logic [3:0]       state_q, state_d, cg_tgt_q, cg_tgt_d;
  logic             cg_req_q, cg_req_d, cg_timeout_q, cg_timeout_d;
  logic [CNT_W-1:0] cg_cnt_q, cg_cnt_d;
  logic             link_q, retrain_q;
  logic             link_fall, retrain_rise;
  logic             fifo_full, fifo_empty, fifo_flush, wr_en;
  logic [BEAT_W-1:0] wr_beat;

  assign link_fall    = link_q && !phy_link_up;
  assign retrain_rise = phy_retrain && !retrain_q;
  assign pl_trdy      = (state_q == ST_ACTIVE) && !fifo_full;
  assign wr_en        = lp_irdy && pl_trdy;
  assign wr_beat      = {lp_data, lp_valid, lp_tlp_start, lp_tlp_end,
                         lp_dllp_start, lp_dllp_end, lp_tlpedb};
  assign fifo_flush   = ((state_q == ST_ACTIVE) || (state_q == ST_RETRAIN)) &&
                        ((state_d == ST_RESET) || (state_d == ST_LINKRESET) ||
                         (state_d == ST_DISABLED));

  assign pl_state_sts   = state_q;
  assign pl_exit_cg_req = cg_req_q;
  assign cg_timeout     = cg_timeout_q;
  assign tx_valid       = !fifo_empty;

  always_comb begin
    state_d      = state_q;
    cg_req_d     = cg_req_q;
    cg_cnt_d     = cg_cnt_q;
    cg_tgt_d     = cg_tgt_q;
    cg_timeout_d = cg_timeout_q;
    if (link_fall && (state_q != ST_DISABLED)) begin
      state_d = ST_RESET;
    end else if ((state_q == ST_ACTIVE) && phy_retrain) begin
      state_d = ST_RETRAIN;
    end else if (lp_state_req == ST_LINKRESET) begin
      state_d = ST_LINKRESET;
    end else if (lp_state_req == ST_DISABLED) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_RESET: if (phy_link_up && (lp_state_req == ST_ACTIVE)) state_d = ST_ACTIVE;
        ST_ACTIVE: if ((lp_state_req == ST_IDLE_L1_1) && fifo_empty) state_d = ST_IDLE_L1_1;
        ST_RETRAIN: begin
          if (!phy_link_up)      state_d = ST_RESET;
          else if (!phy_retrain) state_d = ST_ACTIVE;
        end
        // Exit from L1 waits for the link layer to leave clock gating first.
        ST_IDLE_L1_1: begin
          if (cg_req_q) begin
            if (lp_exit_cg_ack) begin
              cg_req_d = 1'b0;
              state_d  = cg_tgt_q;
            end
          end else if (retrain_rise) begin
            cg_req_d = 1'b1;
            cg_cnt_d = '0;
            cg_tgt_d = ST_RETRAIN;
          end else if (lp_state_req == ST_ACTIVE) begin
            cg_req_d = 1'b1;
            cg_cnt_d = '0;
            cg_tgt_d = ST_ACTIVE;
          end
        end
        ST_LINKRESET, ST_DISABLED: if (lp_state_req == LPIF_NOP) state_d = ST_RESET;
        default: state_d = ST_RESET;
      endcase
    end
    if (state_d != ST_IDLE_L1_1) cg_req_d = 1'b0;
    if (cg_req_q && cg_req_d) begin
      if (cg_cnt_q == CNT_W'(EXIT_CG_TIMEOUT)) cg_timeout_d = 1'b1;
      else cg_cnt_d = cg_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge lclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RESET;
      cg_req_q     <= 1'b0;
      cg_cnt_q     <= '0;
      cg_tgt_q     <= ST_ACTIVE;
      cg_timeout_q <= 1'b0;
      link_q       <= 1'b0;
      retrain_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cg_req_q     <= cg_req_d;
      cg_cnt_q     <= cg_cnt_d;
      cg_tgt_q     <= cg_tgt_d;
      cg_timeout_q <= cg_timeout_d;
      link_q       <= phy_link_up;
      retrain_q    <= phy_retrain;
    end
  end

  lpif_tx_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (lclk),
    .rst_n   (reset_n),
    .flush   (fifo_flush),
    .wr_en   (wr_en),
    .wr_data (wr_beat),
    .rd_en   (tx_ready),
    .rd_data (tx_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef LPIF_FRAMING_CHECK_EN
  logic tlp_open_q, tlp_open_d, dllp_open_q, dllp_open_d, framing_err_q, framing_err_d;

  assign framing_err = framing_err_q;

  // Bytes are walked in order so a start and end in one beat pair up correctly.
  always_comb begin
    tlp_open_d    = tlp_open_q;
    dllp_open_d   = dllp_open_q;
    framing_err_d = framing_err_q;
    if (wr_en) begin
      for (int i = 0; i < FW; i++) begin
        if (!lp_valid[i] && (lp_tlp_start[i] || lp_tlp_end[i] || lp_dllp_start[i] ||
                             lp_dllp_end[i] || lp_tlpedb[i])) framing_err_d = 1'b1;
        if (lp_tlp_start[i]) begin
          if (tlp_open_d || dllp_open_d) framing_err_d = 1'b1;
          tlp_open_d = 1'b1;
        end
        if (lp_tlp_end[i]) begin
          if (!tlp_open_d) framing_err_d = 1'b1;
          tlp_open_d = 1'b0;
        end
        if (lp_dllp_start[i]) begin
          if (tlp_open_d || dllp_open_d) framing_err_d = 1'b1;
          dllp_open_d = 1'b1;
        end
        if (lp_dllp_end[i]) begin
          if (!dllp_open_d) framing_err_d = 1'b1;
          dllp_open_d = 1'b0;
        end
      end
    end
    if (fifo_flush) begin
      tlp_open_d  = 1'b0;
      dllp_open_d = 1'b0;
    end
  end

  always_ff @(posedge lclk or negedge reset_n) begin
    if (!reset_n) begin
      tlp_open_q    <= 1'b0;
      dllp_open_q   <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      tlp_open_q    <= tlp_open_d;
      dllp_open_q   <= dllp_open_d;
      framing_err_q <= framing_err_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lpif_pl_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lpif_pl_responder - vector table plus scoreboard for lpif_pl_responder. Rev 1.0
// ----------------------------------------------------------------------------
module tb_lpif_pl_responder;

  localparam logic [3:0] S_RESET = 4'b0000, S_ACTIVE = 4'b0001, S_IDLE = 4'b0100;
  localparam logic [3:0] S_RETRAIN = 4'b1011, S_LINKRESET = 4'b1001, S_DISABLED = 4'b1100;

  logic        lclk, reset_n;
  logic [3:0]  lp_state_req, pl_state_sts;
  logic        lp_irdy, pl_trdy, pl_exit_cg_req, lp_exit_cg_ack;
  logic [31:0] lp_data;
  logic [3:0]  lp_valid, lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end, lp_tlpedb;
  logic        phy_link_up, phy_retrain, tx_valid, tx_ready, cg_timeout;
  logic [55:0] tx_data;
`ifdef LPIF_FRAMING_CHECK_EN
  logic        framing_err;
`endif

  lpif_pl_responder #(
    .BUS_WIDTH(32), .FIFO_DEPTH(4), .EXIT_CG_TIMEOUT(255)
  ) dut (
    .lclk(lclk), .reset_n(reset_n), .lp_state_req(lp_state_req), .pl_state_sts(pl_state_sts),
    .lp_irdy(lp_irdy), .lp_data(lp_data), .lp_valid(lp_valid), .lp_tlp_start(lp_tlp_start),
    .lp_tlp_end(lp_tlp_end), .lp_dllp_start(lp_dllp_start), .lp_dllp_end(lp_dllp_end),
    .lp_tlpedb(lp_tlpedb), .pl_trdy(pl_trdy), .pl_exit_cg_req(pl_exit_cg_req),
    .lp_exit_cg_ack(lp_exit_cg_ack), .phy_link_up(phy_link_up), .phy_retrain(phy_retrain),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .cg_timeout(cg_timeout)
`ifdef LPIF_FRAMING_CHECK_EN
    , .framing_err(framing_err)
`endif
  );

  initial lclk = 1'b0;
  always #5 lclk = ~lclk;

  typedef struct {
    logic [3:0]  req;
    logic        link;
    logic        retrain;
    logic        irdy;
    logic        rdy;
    logic [31:0] data;
    logic [3:0]  exp;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [3:0]  exp_state = S_RESET;
  logic [55:0] sb[$];
  vec_t        vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] req, input logic link, input logic ret,
                              input logic irdy, input logic rdy, input logic [31:0] data,
                              input logic [3:0] exp);
    vec_t v;
    v.req = req; v.link = link; v.retrain = ret; v.irdy = irdy; v.rdy = rdy;
    v.data = data; v.exp = exp;
    return v;
  endfunction

  // One clock: check handshake outputs and head beat, update scoreboard, check next state.
  task automatic step(input logic [3:0] nxt);
    logic        m_trdy, rd, acc;
    logic [55:0] beat;
    m_trdy = (exp_state == S_ACTIVE) && (sb.size() < 4);
    rd     = tx_ready && (sb.size() > 0);
    acc    = lp_irdy && m_trdy;
    beat   = {lp_data, lp_valid, lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end, lp_tlpedb};
    chk("pl_trdy", {63'd0, pl_trdy}, {63'd0, m_trdy});
    chk("tx_valid", {63'd0, tx_valid}, {63'd0, sb.size() > 0});
    if (rd) begin
      chk("tx_data", {8'd0, tx_data}, {8'd0, sb[0]});
      void'(sb.pop_front());
    end
    if (acc) sb.push_back(beat);
    @(posedge lclk);
    @(negedge lclk);
    if (((exp_state == S_ACTIVE) || (exp_state == S_RETRAIN)) &&
        ((nxt == S_RESET) || (nxt == S_LINKRESET) || (nxt == S_DISABLED))) sb.delete();
    chk("pl_state_sts", {60'd0, pl_state_sts}, {60'd0, nxt});
    exp_state = nxt;
  endtask

  initial begin
    reset_n = 1'b0; lp_state_req = 4'd0; lp_irdy = 1'b0; lp_data = '0; lp_valid = 4'hF;
    lp_tlp_start = '0; lp_tlp_end = '0; lp_dllp_start = '0; lp_dllp_end = '0; lp_tlpedb = '0;
    lp_exit_cg_ack = 1'b0; phy_link_up = 1'b0; phy_retrain = 1'b0; tx_ready = 1'b0;

    // Bring-up, fill to full, simultaneous read/write, drain gating L1 entry.
    vt.push_back(mk(S_ACTIVE, 1, 0, 0, 0, 32'h0,        S_ACTIVE));
    vt.push_back(mk(S_ACTIVE, 1, 0, 1, 0, 32'h11111111, S_ACTIVE));
    vt.push_back(mk(S_ACTIVE, 1, 0, 1, 0, 32'h22222222, S_ACTIVE));
    vt.push_back(mk(S_ACTIVE, 1, 0, 1, 0, 32'h33333333, S_ACTIVE));
    vt.push_back(mk(S_ACTIVE, 1, 0, 1, 0, 32'h44444444, S_ACTIVE));
    vt.push_back(mk(S_ACTIVE, 1, 0, 1, 0, 32'h55555555, S_ACTIVE));
    vt.push_back(mk(S_ACTIVE, 1, 0, 1, 1, 32'h55555555, S_ACTIVE));
    vt.push_back(mk(S_ACTIVE, 1, 0, 1, 0, 32'h55555555, S_ACTIVE));
    vt.push_back(mk(S_ACTIVE, 1, 0, 1, 1, 32'h66666666, S_ACTIVE));
    vt.push_back(mk(S_ACTIVE, 1, 0, 1, 1, 32'h66666666, S_ACTIVE));
    vt.push_back(mk(S_ACTIVE, 1, 0, 0, 1, 32'h0,        S_ACTIVE));
    vt.push_back(mk(S_IDLE,   1, 0, 0, 0, 32'h0,        S_ACTIVE));
    vt.push_back(mk(S_IDLE,   1, 0, 0, 0, 32'h0,        S_ACTIVE));
    vt.push_back(mk(S_IDLE,   1, 0, 0, 1, 32'h0,        S_ACTIVE));
    vt.push_back(mk(S_IDLE,   1, 0, 0, 1, 32'h0,        S_ACTIVE));
    vt.push_back(mk(S_IDLE,   1, 0, 0, 0, 32'h0,        S_IDLE));
    vt.push_back(mk(S_IDLE,   1, 0, 1, 0, 32'h77777777, S_IDLE));

    @(negedge lclk);
    @(negedge lclk);
    chk("rst_state", {60'd0, pl_state_sts}, 64'd0);
    chk("rst_trdy", {63'd0, pl_trdy}, 64'd0);
    chk("rst_cg_req", {63'd0, pl_exit_cg_req}, 64'd0);
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_cg_timeout", {63'd0, cg_timeout}, 64'd0);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      lp_state_req = vt[i].req; phy_link_up = vt[i].link; phy_retrain = vt[i].retrain;
      lp_irdy = vt[i].irdy; tx_ready = vt[i].rdy; lp_data = vt[i].data;
      step(vt[i].exp);
    end

    // Exit from L1 without ack: request held, timeout sets, ack completes exit.
    lp_irdy = 1'b0; tx_ready = 1'b0; lp_state_req = S_ACTIVE;
    step(S_IDLE);
    chk("cg_req_set", {63'd0, pl_exit_cg_req}, 64'd1);
    for (int i = 0; i < 300; i++) begin
      step(S_IDLE);
      if (i == 100) chk("cg_timeout_early", {63'd0, cg_timeout}, 64'd0);
    end
    chk("cg_timeout", {63'd0, cg_timeout}, 64'd1);
    chk("cg_req_held", {63'd0, pl_exit_cg_req}, 64'd1);
    lp_exit_cg_ack = 1'b1;
    for (int i = 0; i < 4 && pl_state_sts != S_ACTIVE; i++) begin
      @(posedge lclk);
      @(negedge lclk);
    end
    chk("cg_exit_state", {60'd0, pl_state_sts}, {60'd0, S_ACTIVE});
    chk("cg_req_cleared", {63'd0, pl_exit_cg_req}, 64'd0);
    exp_state = S_ACTIVE;
    step(S_ACTIVE);
    chk("ack_no_req", {63'd0, pl_exit_cg_req}, 64'd0);
    lp_exit_cg_ack = 1'b0;

    // Retrain beats an L1 request; link loss from RETRAIN flushes the buffer.
    lp_irdy = 1'b1; lp_data = 32'hAAAA0001; step(S_ACTIVE);
    lp_data = 32'hAAAA0002; step(S_ACTIVE);
    lp_irdy = 1'b0; phy_retrain = 1'b1; lp_state_req = S_IDLE;
    step(S_RETRAIN);
    phy_link_up = 1'b0;
    step(S_RESET);
    phy_retrain = 1'b0; lp_state_req = S_RESET;
    step(S_RESET);
    chk("cg_timeout_sticky", {63'd0, cg_timeout}, 64'd1);

    // LINKRESET/DISABLED entry and exit; DISABLED ignores link loss.
    lp_state_req = S_LINKRESET; step(S_LINKRESET);
    lp_state_req = 4'b0000;     step(S_RESET);
    lp_state_req = S_DISABLED; phy_link_up = 1'b1; step(S_DISABLED);
    phy_link_up = 1'b0;         step(S_DISABLED);
    lp_state_req = 4'b0000;     step(S_RESET);

`ifdef LPIF_FRAMING_CHECK_EN
    phy_link_up = 1'b1; lp_state_req = S_ACTIVE; step(S_ACTIVE);
    lp_irdy = 1'b1; lp_tlp_start = 4'b0001; lp_data = 32'hBBBB0001;
    step(S_ACTIVE);
    chk("framing_first_start", {63'd0, framing_err}, 64'd0);
    lp_data = 32'hBBBB0002;
    step(S_ACTIVE);
    chk("framing_double_start", {63'd0, framing_err}, 64'd1);
    lp_irdy = 1'b0; lp_tlp_start = 4'b0000;
    step(S_ACTIVE);
    chk("framing_sticky", {63'd0, framing_err}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("framing_reset", {63'd0, framing_err}, 64'd0);
    chk("framing_reset_state", {60'd0, pl_state_sts}, 64'd0);
    chk("framing_reset_tx_valid", {63'd0, tx_valid}, 64'd0);
    sb.delete();
    exp_state = S_RESET;
    @(negedge lclk);
    reset_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
